// File: rtl/alu_instr_sequencer_if.sv
// Control-unit bundle between the instruction sequencer (master) and the datapath (slave).
// start is a level request: it is taken in IDLE or in the done state, with no acknowledge beyond busy/done.
interface alu_instr_sequencer_if #(
   parameter int NUM_REGS = 16,
   parameter int ALUOP_W  = 4
);
   logic                start;
   logic                mem_ready;
   logic [31:0]         ir;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
   logic                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
   logic [ALUOP_W-1:0]  ALUop;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      input  start, mem_ready, ir,
      output Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
             Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, ALUop, busy, done, err
   );

   modport slave (
      output start, mem_ready, ir,
      input  Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
             Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, ALUop, busy, done, err
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Hardwired T0..T6 control sequencer: fetch, decode IR, and drive datapath strobes
// for reg-reg ALU, unary ALU and mul/div (HI/LO) instructions.
module alu_instr_sequencer #(
   parameter int NUM_REGS = 16,
   parameter int ALUOP_W  = 4
) (
   input  logic                        clock,
   input  logic                        clear,
   alu_instr_sequencer_if.master       bus,
   output logic [2:0]                  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      C_RR  = 2'd0,
      C_MD  = 2'd1,
      C_UN  = 2'd2,
      C_ILL = 2'd3
   } cls_t;

   localparam logic [4:0] NREG = 5'(NUM_REGS);

   state_t     state_q, state_d;
   cls_t       cls;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       bad;
   state_t     fin_next;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
      onehot = NUM_REGS'(1) << idx;
   endfunction

   assign opcode = bus.ir[31:27];
   assign ra     = bus.ir[26:23];
   assign rb     = bus.ir[22:19];
   assign rc     = bus.ir[18:15];

   always_comb begin
      if (opcode < 5'd12)       cls = C_RR;
      else if (opcode < 5'd14)  cls = C_MD;
      else if (opcode < 5'd16)  cls = C_UN;
      else                      cls = C_ILL;
   end

   // Every class reads ra and rb; only reg-reg also uses rc.
   assign bad = (cls == C_ILL) || ({1'b0, ra} >= NREG) || ({1'b0, rb} >= NREG) ||
                ((cls == C_RR) && ({1'b0, rc} >= NREG));

   assign fin_next  = bus.start ? S_T0 : S_IDLE;
   assign dbg_state = state_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      bus.Rin      = '0;
      bus.Rout     = '0;
      bus.PCout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.MARin    = 1'b0;
      bus.Read     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zlowin   = 1'b0;
      bus.Zhighin  = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.ALUop    = '0;
      bus.done     = 1'b0;
      bus.err      = 1'b0;
      bus.busy     = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: if (bus.start) state_d = S_T0;
         S_T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zlowin = 1'b1;
            state_d    = S_T1;
         end
         S_T1: begin
            // Held for the whole memory stall; re-latching PC and MDR is harmless.
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            if (bus.mem_ready) state_d = S_T2;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = S_T3;
         end
         S_T3: begin
            if (bad) begin
               bus.done = 1'b1;
               bus.err  = 1'b1;
               state_d  = fin_next;
            end else begin
               state_d = S_T4;
               case (cls)
                  C_RR: begin bus.Rout = onehot(rb); bus.Yin = 1'b1; end
                  C_MD: begin bus.Rout = onehot(ra); bus.Yin = 1'b1; end
                  default: begin
                     bus.Rout   = onehot(rb);
                     bus.ALUop  = ALUOP_W'(opcode);
                     bus.Zlowin = 1'b1;
                  end
               endcase
            end
         end
         S_T4: begin
            state_d = S_T5;
            case (cls)
               C_RR: begin
                  bus.Rout   = onehot(rc);
                  bus.ALUop  = ALUOP_W'(opcode);
                  bus.Zlowin = 1'b1;
               end
               C_MD: begin
                  bus.Rout    = onehot(rb);
                  bus.ALUop   = ALUOP_W'(opcode);
                  bus.Zlowin  = 1'b1;
                  bus.Zhighin = 1'b1;
               end
               C_UN: begin
                  bus.Zlowout = 1'b1;
                  bus.Rin     = onehot(ra);
                  bus.done    = 1'b1;
                  state_d     = fin_next;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (cls == C_MD) begin
               bus.LOin = 1'b1;
               state_d  = S_T6;
            end else begin
               bus.Rin  = onehot(ra);
               bus.done = 1'b1;
               state_d  = fin_next;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.done     = 1'b1;
            state_d      = fin_next;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: cycle-by-cycle model of the T-state strobes,
// plus literal checks of latency and key strobe values; a second instance uses NUM_REGS=8.
module tb_alu_instr_sequencer;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcout, pcin, incpc, marin, read, mdrin, mdrout, irin, yin;
      logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
      logic [3:0] aluop;
      logic busy, done, err;
   } obs_t;

   localparam int OW = $bits(obs_t);

   logic clock;
   logic clear;
   logic [2:0] dbg1, dbg8;

   logic [OW-1:0] exp_q[$];
   obs_t          trace_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            lat_cnt = 0;
   int            last_lat = 0;
   obs_t          cmp_o, cmp_e;

   alu_instr_sequencer_if #(.NUM_REGS(16), .ALUOP_W(4)) if1 ();
   alu_instr_sequencer_if #(.NUM_REGS(8),  .ALUOP_W(4)) if8 ();

   alu_instr_sequencer #(.NUM_REGS(16), .ALUOP_W(4)) dut (
     .clock(clock), .clear(clear), .bus(if1.master), .dbg_state(dbg1));
   alu_instr_sequencer #(.NUM_REGS(8), .ALUOP_W(4)) dut8 (
     .clock(clock), .clear(clear), .bus(if8.master), .dbg_state(dbg8));

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
     #200000;
     $display("FAIL watchdog: got=timeout required=finish");
     $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
     n_vec++;
     if (got !== exp) begin
       n_err++;
       $display("FAIL %s @%0t: got=%h required=%h", name, $time, got, exp);
     end
   endtask

   function automatic obs_t sample1();
     obs_t o;
     o.rin = if1.Rin; o.rout = if1.Rout;
     o.pcout = if1.PCout; o.pcin = if1.PCin; o.incpc = if1.IncPC; o.marin = if1.MARin;
     o.read = if1.Read; o.mdrin = if1.MDRin; o.mdrout = if1.MDRout; o.irin = if1.IRin;
     o.yin = if1.Yin; o.zlowin = if1.Zlowin; o.zhighin = if1.Zhighin;
     o.zlowout = if1.Zlowout; o.zhighout = if1.Zhighout; o.hiin = if1.HIin; o.loin = if1.LOin;
     o.aluop = if1.ALUop; o.busy = if1.busy; o.done = if1.done; o.err = if1.err;
     return o;
   endfunction

   // ---------------- scoreboard / compare ----------------
   always @(negedge clock) begin
     cmp_o = sample1();
     trace_q.push_back(cmp_o);
     if (cmp_o.busy) begin
       lat_cnt++;
       if (cmp_o.done) begin
         last_lat = lat_cnt;
         lat_cnt  = 0;
       end
     end else begin
       lat_cnt = 0;
     end
     if (exp_q.size() > 0) begin
       cmp_e = exp_q.pop_front();
       chk("cycle", 64'(cmp_o), 64'(cmp_e));
     end
   end

   // ---------------- model ----------------
   function automatic obs_t v_idle();
     obs_t v = '0;
     return v;
   endfunction

   function automatic obs_t v_t0();
     obs_t v = '0;
     v.busy = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zlowin = 1;
     return v;
   endfunction

   function automatic obs_t v_t1();
     obs_t v = '0;
     v.busy = 1; v.zlowout = 1; v.pcin = 1; v.read = 1; v.mdrin = 1;
     return v;
   endfunction

   function automatic obs_t v_t2();
     obs_t v = '0;
     v.busy = 1; v.mdrout = 1; v.irin = 1;
     return v;
   endfunction

   // ---------------- drivers ----------------
   task automatic cycle(input logic st, input logic mr, input obs_t e);
     if1.start = st;
     if1.mem_ready = mr;
     exp_q.push_back(e);
     @(posedge clock); #1;
   endtask

   // Execute-phase steps derived from opcode class and register range.
   task automatic run(input logic [31:0] i, input int stalls, input logic nxt);
     obs_t st[4];
     obs_t v;
     int n;
     int nregs = 16;
     logic [4:0] op;
     logic [3:0] ra, rb, rc;
     logic bad;
     op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
     if1.ir = i;
     bad = (op >= 16) || (ra >= nregs) || (rb >= nregs) || (op < 12 && rc >= nregs);
     n = 0;
     if (bad) begin
       v = '0; v.busy = 1; v.done = 1; v.err = 1; st[0] = v; n = 1;
     end else if (op < 12) begin
       v = '0; v.busy = 1; v.rout = 16'h1 << rb; v.yin = 1; st[0] = v;
       v = '0; v.busy = 1; v.rout = 16'h1 << rc; v.aluop = op[3:0]; v.zlowin = 1; st[1] = v;
       v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'h1 << ra; v.done = 1; st[2] = v;
       n = 3;
     end else if (op < 14) begin
       v = '0; v.busy = 1; v.rout = 16'h1 << ra; v.yin = 1; st[0] = v;
       v = '0; v.busy = 1; v.rout = 16'h1 << rb; v.aluop = op[3:0]; v.zlowin = 1; v.zhighin = 1; st[1] = v;
       v = '0; v.busy = 1; v.zlowout = 1; v.loin = 1; st[2] = v;
       v = '0; v.busy = 1; v.zhighout = 1; v.hiin = 1; v.done = 1; st[3] = v;
       n = 4;
     end else begin
       v = '0; v.busy = 1; v.rout = 16'h1 << rb; v.aluop = op[3:0]; v.zlowin = 1; st[0] = v;
       v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'h1 << ra; v.done = 1; st[1] = v;
       n = 2;
     end
     cycle(0, 1, v_t0());
     for (int s = 0; s < stalls; s++) cycle(0, 0, v_t1());
     cycle(0, 1, v_t1());
     cycle(0, 1, v_t2());
     for (int k = 0; k < n - 1; k++) cycle(0, 1, st[k]);
     cycle(nxt, 1, st[n-1]);
   endtask

   // From IDLE: start request, one instruction, then one IDLE cycle.
   task automatic issue(input logic [31:0] i, input int stalls);
     if1.ir = i;
     cycle(1, 1, v_idle());
     trace_q.delete();
     run(i, stalls, 0);
     cycle(0, 1, v_idle());
   endtask

   task automatic run8(input string name, input logic [31:0] i, input logic exp_err,
                       input logic [7:0] exp_rin, input int exp_lat);
     int n;
     if8.ir = i; if8.mem_ready = 1; if8.start = 1;
     @(posedge clock); #1;
     if8.start = 0;
     n = 0;
     while (!if8.done && n < 20) begin
       @(posedge clock); #1;
       n++;
     end
     chk({name, "_lat"}, 64'(n + 1), 64'(exp_lat));
     chk({name, "_err"}, 64'(if8.err), 64'(exp_err));
     chk({name, "_rin"}, 64'(if8.Rin), 64'(exp_rin));
     chk({name, "_rout"}, 64'(if8.Rout), 64'h0);
     @(posedge clock); #1;
     chk({name, "_idle"}, 64'(if8.busy), 64'h0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] tbl_ir[6]  = '{32'h07870000, 32'h59CE0000, 32'h68780000,
                               32'h7FF80000, 32'h80000000, 32'hF8000000};
   int          tbl_st[6]  = '{0, 1, 0, 2, 0, 1};
   int          tbl_lat[6] = '{6, 7, 7, 7, 4, 5};

   initial begin
     clear = 1'b1;
     if1.start = 0; if1.mem_ready = 0; if1.ir = '0;
     if8.start = 0; if8.mem_ready = 0; if8.ir = '0;
     #2 clear = 1'b0;
     #1;
     chk("reset_outputs", 64'(sample1()), 64'h0);
     repeat (2) @(posedge clock);
     @(negedge clock) clear = 1'b1;
     @(posedge clock); #1;
     chk("reset_busy", 64'(if1.busy), 64'h0);

     // sub R2,R5,R6
     issue(32'h212B0000, 0);
     chk("sub_lat", 64'(last_lat), 64'd6);
     chk("sub_t0_pcout", 64'(trace_q[0].pcout), 64'h1);
     chk("sub_t3_rout", 64'(trace_q[3].rout), 64'h0020);
     chk("sub_t4_rout", 64'(trace_q[4].rout), 64'h0040);
     chk("sub_t4_aluop", 64'(trace_q[4].aluop), 64'd4);
     chk("sub_t5_rin", 64'(trace_q[5].rin), 64'h0004);
     chk("sub_t5_done", 64'(trace_q[5].done), 64'h1);
     chk("sub_idle_busy", 64'(trace_q[6].busy), 64'h0);

     // mul R3,R4
     issue(32'h61A00000, 0);
     chk("mul_lat", 64'(last_lat), 64'd7);
     chk("mul_t3_rout", 64'(trace_q[3].rout), 64'h0008);
     chk("mul_t4_rout", 64'(trace_q[4].rout), 64'h0010);
     chk("mul_t4_aluop", 64'(trace_q[4].aluop), 64'd12);
     chk("mul_t4_zhighin", 64'(trace_q[4].zhighin), 64'h1);
     chk("mul_t5_loin", 64'(trace_q[5].loin), 64'h1);
     chk("mul_t6_hiin", 64'(trace_q[6].hiin), 64'h1);

     // sub with a three-cycle memory stall
     issue(32'h212B0000, 3);
     chk("stall_lat", 64'(last_lat), 64'd9);
     chk("stall_t1_read", 64'(trace_q[4].read), 64'h1);
     chk("stall_t2_irin", 64'(trace_q[5].irin), 64'h1);

     // neg R1,R7
     issue(32'h70B80000, 0);
     chk("neg_lat", 64'(last_lat), 64'd5);
     chk("neg_t3_rout", 64'(trace_q[3].rout), 64'h0080);
     chk("neg_t3_aluop", 64'(trace_q[3].aluop), 64'd14);
     chk("neg_t4_rin", 64'(trace_q[4].rin), 64'h0002);

     // illegal opcode 20
     issue(32'hA0000000, 0);
     chk("ill_lat", 64'(last_lat), 64'd4);
     chk("ill_t3_err", 64'(trace_q[3].err), 64'h1);
     chk("ill_t3_rinrout", 64'({trace_q[3].rin, trace_q[3].rout}), 64'h0);
     chk("ill_idle_busy", 64'(trace_q[4].busy), 64'h0);

     // boundary opcodes, extreme register indices, assorted stalls
     for (int t = 0; t < 6; t++) begin
       issue(tbl_ir[t], tbl_st[t]);
       chk($sformatf("tbl%0d_lat", t), 64'(last_lat), 64'(tbl_lat[t]));
     end

     // clear mid-instruction during T4 of sub
     if1.ir = 32'h212B0000;
     cycle(1, 1, v_idle());
     cycle(0, 1, v_t0());
     cycle(0, 1, v_t1());
     cycle(0, 1, v_t2());
     begin
       obs_t v = '0;
       v.busy = 1; v.rout = 16'h0020; v.yin = 1;
       cycle(0, 1, v);
     end
     chk("abort_in_t4", 64'(if1.Zlowin), 64'h1);
     #2 clear = 1'b0;
     #1;
     chk("abort_outputs", 64'(sample1()), 64'h0);
     chk("abort_busy", 64'(if1.busy), 64'h0);
     @(negedge clock) clear = 1'b1;
     @(posedge clock); #1;
     issue(32'h212B0000, 0);
     chk("restart_lat", 64'(last_lat), 64'd6);

     // back-to-back: sub then not R4,R9, no IDLE in between
     if1.ir = 32'h212B0000;
     cycle(1, 1, v_idle());
     trace_q.delete();
     run(32'h212B0000, 0, 1);
     run(32'h7A480000, 0, 0);
     cycle(0, 1, v_idle());
     chk("b2b_t0_after_done", 64'({trace_q[6].busy, trace_q[6].pcout}), 64'h3);
     chk("b2b_lat2", 64'(last_lat), 64'd5);

     // NUM_REGS=8 instance: range checks
     run8("r8_rc9", 32'h18948000, 1'b1, 8'h00, 4);
     run8("r8_rc7", 32'h188B8000, 1'b0, 8'h02, 6);
     run8("r8_ra8", 32'h74000000, 1'b1, 8'h00, 4);

     repeat (2) @(posedge clock);
     #1;
     chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
     $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
     $finish;
   end

endmodule
